// File: rtl/mult_res_collect.sv
// Collects unstallable multiplier results in a FIFO and returns them over valid/ready; one cycle
// FIFO latency plus output register. Issue-side credits give every result a guaranteed slot.
module mult_res_collect #(
   parameter int DEPTH = 32,
   parameter int CW    = 6
) (
   input  logic        ck,
   input  logic        rst_n,
   input  logic        i_issue,
   output logic        o_issue_rdy,
   input  logic [63:0] i_res,
   input  logic [8:0]  i_htId,
   input  logic        i_vld,
   output logic [63:0] o_res,
   output logic [8:0]  o_htId,
   output logic        o_vld,
   input  logic        i_rdy,
   output logic        o_idle,
   output logic [1:0]  o_err,
   output logic [31:0] o_done_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CAP = CW'(DEPTH + 1);

   typedef struct packed {
      logic [63:0] res;
      logic [8:0]  ht_id;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   entry_t        out_q, out_d;
   logic          vld_q, vld_d;
   logic [CW-1:0] cred_q, cred_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   done_q, done_d;
   logic          fifo_empty, fifo_full, pop, push, hs, issue_acc, cred_dec;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      hs         = vld_q & i_rdy;
      pop        = !fifo_empty && (!vld_q || i_rdy);
      // A pop on the same edge frees the slot, so a push into a full FIFO is still kept.
      push       = i_vld && (!fifo_full || pop);
      issue_acc  = i_issue && (cred_q < CAP);
      cred_dec   = hs && (cred_q != '0);

      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

      out_d = out_q;
      vld_d = vld_q;
      if (pop) begin
         out_d = mem_q[rd_ptr_q[AW-1:0]];
         vld_d = 1'b1;
      end else if (hs) begin
         vld_d = 1'b0;
      end

      cred_d = cred_q;
      if (issue_acc && !cred_dec) begin
         cred_d = cred_q + 1'b1;
      end else if (!issue_acc && cred_dec) begin
         cred_d = cred_q - 1'b1;
      end

      err_d  = err_q | {i_issue & ~issue_acc, i_vld & ~push};
      done_d = done_q + {31'd0, hs};
   end

   always_ff @(posedge ck) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= '{res: i_res, ht_id: i_htId};
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
         vld_q    <= 1'b0;
         cred_q   <= '0;
         err_q    <= '0;
         done_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
         vld_q    <= vld_d;
         cred_q   <= cred_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign o_res       = out_q.res;
   assign o_htId      = out_q.ht_id;
   assign o_vld       = vld_q;
   assign o_issue_rdy = (cred_q < CAP);
   assign o_idle      = (cred_q == '0);
   assign o_err       = err_q;
   assign o_done_cnt  = done_q;

endmodule

// File: tb/tb_mult_res_collect.sv
// Randomised bench for mult_res_collect with a queue-based reference model of ordering and credits.
module tb_mult_res_collect;
   localparam int DEPTH = 32;
   localparam int CAP   = DEPTH + 1;

   logic        ck = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_issue = 1'b0;
   logic        o_issue_rdy;
   logic [63:0] i_res = '0;
   logic [8:0]  i_htId = '0;
   logic        i_vld = 1'b0;
   logic [63:0] o_res;
   logic [8:0]  o_htId;
   logic        o_vld;
   logic        i_rdy = 1'b0;
   logic        o_idle;
   logic [1:0]  o_err;
   logic [31:0] o_done_cnt;

   typedef logic [72:0] item_t;

   item_t got_q[$];
   item_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    exp_done = 0;

   mult_res_collect #(.DEPTH(DEPTH), .CW(6)) dut (
      .ck(ck), .rst_n(rst_n), .i_issue(i_issue), .o_issue_rdy(o_issue_rdy),
      .i_res(i_res), .i_htId(i_htId), .i_vld(i_vld),
      .o_res(o_res), .o_htId(o_htId), .o_vld(o_vld), .i_rdy(i_rdy),
      .o_idle(o_idle), .o_err(o_err), .o_done_cnt(o_done_cnt)
   );

   always #5 ck = ~ck;

   // Monitor: records every output handshake, sampled mid-cycle.
   always @(negedge ck) begin
      if (rst_n && o_vld && i_rdy) got_q.push_back({o_res, o_htId});
   end

   task automatic nxt();
      @(posedge ck);
      #1;
   endtask

   function automatic item_t rand_item();
      item_t it;
      it = {$urandom, $urandom, 9'($urandom)};
      return it;
   endfunction

   task automatic wait_got(input int n, input int limit, output bit ok);
      int c = 0;
      while (got_q.size() < n && c < limit) begin
         nxt();
         c++;
      end
      ok = (got_q.size() >= n);
   endtask

   task automatic issue_n(input int n);
      i_issue = 1'b1;
      repeat (n) nxt();
      i_issue = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_vld = 1'b1; i_issue = 1'b1; i_rdy = 1'b1;
      nxt(); nxt();
      checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_vld); end
      checks++; if (o_res !== 64'd0 || o_htId !== 9'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", o_res, o_htId); end
      checks++; if (o_issue_rdy !== 1'b1 || o_idle !== 1'b1) begin errors++; $display("FAIL reset_rdy_idle got=%b%b exp=11", o_issue_rdy, o_idle); end
      checks++; if (o_err !== 2'b00 || o_done_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_done got=%b/%0d exp=00/0", o_err, o_done_cnt); end
      i_vld = 1'b0; i_issue = 1'b0; i_rdy = 1'b0;
      rst_n = 1'b1;
      nxt();
   endtask

   task automatic test_latency();
      item_t it = {64'h3FF0000000000000, 9'h1A5};
      got_q.delete();
      issue_n(1);
      checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL lat_idle_busy got=%b exp=0", o_idle); end
      i_rdy = 1'b1;
      i_vld = 1'b1; {i_res, i_htId} = it;
      nxt();
      i_vld = 1'b0;
      checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL lat_no_bypass got=%b exp=0", o_vld); end
      nxt();
      checks++; if (o_vld !== 1'b1 || {o_res, o_htId} !== it) begin errors++; $display("FAIL lat_out got=%b %h exp=1 %h", o_vld, {o_res, o_htId}, it); end
      nxt();
      exp_done += 1;
      checks++; if (o_vld !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL lat_after got vld=%b idle=%b exp 0 1", o_vld, o_idle); end
      checks++; if (o_done_cnt !== 32'(exp_done) || got_q.size() != 1) begin errors++; $display("FAIL lat_done got=%0d/%0d exp=%0d/1", o_done_cnt, got_q.size(), exp_done); end
      i_rdy = 1'b0;
   endtask

   task automatic test_stall_fill();
      int cr = 0;
      bit ok;
      item_t it;
      got_q.delete(); exp_q.delete();
      i_rdy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         i_issue = 1'b1;
         checks++; if (o_issue_rdy !== (cr < CAP)) begin errors++; $display("FAIL fill_issue_rdy i=%0d got=%b exp=%b", i, o_issue_rdy, cr < CAP); end
         if (cr < CAP) cr++;
         nxt();
         checks++; if (o_err[1] !== (i >= CAP)) begin errors++; $display("FAIL fill_err1 i=%0d got=%b exp=%b", i, o_err[1], i >= CAP); end
      end
      i_issue = 1'b0;
      for (int i = 0; i < CAP; i++) begin
         it = rand_item();
         exp_q.push_back(it);
         i_vld = 1'b1; {i_res, i_htId} = it;
         nxt();
      end
      i_vld = 1'b0;
      checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL fill_no_drop got=%b exp=0", o_err[0]); end
      i_rdy = 1'b1;
      wait_got(CAP, 200, ok);
      nxt(); nxt();
      checks++; if (!ok || got_q.size() != CAP) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", got_q.size(), CAP); end
      for (int k = 0; k < CAP && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL fill_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
      exp_done += CAP;
      checks++; if (o_idle !== 1'b1 || o_done_cnt !== 32'(exp_done)) begin errors++; $display("FAIL fill_end got idle=%b done=%0d exp 1 %0d", o_idle, o_done_cnt, exp_done); end
      i_rdy = 1'b0;
   endtask

   task automatic test_corner_full_push_pop();
      bit ok;
      item_t it;
      got_q.delete(); exp_q.delete();
      i_rdy = 1'b0;
      issue_n(CAP);
      for (int i = 0; i < CAP; i++) begin
         it = rand_item();
         exp_q.push_back(it);
         i_vld = 1'b1; {i_res, i_htId} = it;
         nxt();
      end
      i_vld = 1'b0;
      nxt();
      it = rand_item();
      exp_q.push_back(it);
      i_vld = 1'b1; {i_res, i_htId} = it; i_rdy = 1'b1;
      nxt();
      i_vld = 1'b0; i_rdy = 1'b0;
      checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL corner_no_drop got=%b exp=0", o_err[0]); end
      checks++; if (o_vld !== 1'b1 || {o_res, o_htId} !== exp_q[1]) begin errors++; $display("FAIL corner_head got=%b %h exp=1 %h", o_vld, {o_res, o_htId}, exp_q[1]); end
      issue_n(1);
      i_rdy = 1'b1;
      wait_got(CAP + 1, 200, ok);
      nxt(); nxt();
      checks++; if (!ok || got_q.size() != CAP + 1) begin errors++; $display("FAIL corner_count got=%0d exp=%0d", got_q.size(), CAP + 1); end
      for (int k = 0; k < CAP + 1 && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL corner_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
      exp_done += CAP + 1;
      checks++; if (o_idle !== 1'b1 || o_done_cnt !== 32'(exp_done)) begin errors++; $display("FAIL corner_end got idle=%b done=%0d exp 1 %0d", o_idle, o_done_cnt, exp_done); end
      i_rdy = 1'b0;
   endtask

   task automatic test_overflow();
      bit ok;
      item_t it;
      got_q.delete(); exp_q.delete();
      i_rdy = 1'b0;
      issue_n(CAP);
      for (int i = 0; i < CAP + 1; i++) begin
         it = rand_item();
         if (i < CAP) exp_q.push_back(it);
         i_vld = 1'b1; {i_res, i_htId} = it;
         nxt();
         checks++; if (o_err[0] !== (i >= CAP)) begin errors++; $display("FAIL ovf_err0 i=%0d got=%b exp=%b", i, o_err[0], i >= CAP); end
      end
      i_vld = 1'b0;
      i_rdy = 1'b1;
      wait_got(CAP, 200, ok);
      repeat (4) nxt();
      checks++; if (!ok || got_q.size() != CAP) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), CAP); end
      for (int k = 0; k < CAP && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
      exp_done += CAP;
      i_rdy = 1'b0;
   endtask

   task automatic test_stream();
      int cr = 0, issued = 0, pend = 0, cyc = 0, bad = 0;
      bit hs, acc;
      item_t it;
      got_q.delete(); exp_q.delete();
      while (got_q.size() < 1000 && cyc < 20000) begin
         i_rdy   = 1'($urandom_range(0, 1));
         i_issue = (issued < 1000);
         i_vld   = (pend > 0);
         if (pend > 0) begin
            it = rand_item();
            exp_q.push_back(it);
            {i_res, i_htId} = it;
            pend--;
         end
         hs  = o_vld & i_rdy;
         acc = i_issue && (cr < CAP);
         checks++;
         if (o_issue_rdy !== (cr < CAP) || o_idle !== (cr == 0)) begin
            errors++;
            if (bad++ < 5) $display("FAIL stream_credit cyc=%0d got rdy=%b idle=%b exp %b %b", cyc, o_issue_rdy, o_idle, cr < CAP, cr == 0);
         end
         nxt();
         if (acc) begin cr++; issued++; pend++; end
         if (hs) cr--;
         cyc++;
      end
      i_issue = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
      nxt();
      checks++; if (got_q.size() != 1000) begin errors++; $display("FAIL stream_count got=%0d exp=1000", got_q.size()); end
      bad = 0;
      for (int k = 0; k < 1000 && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== exp_q[k]) begin
            errors++;
            if (bad++ < 5) $display("FAIL stream_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
         end
      end
      exp_done += 1000;
      checks++; if (o_done_cnt !== 32'(exp_done) || o_idle !== 1'b1) begin errors++; $display("FAIL stream_end got done=%0d idle=%b exp %0d 1", o_done_cnt, o_idle, exp_done); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      item_t it;
      i_rdy = 1'b0;
      issue_n(3);
      for (int i = 0; i < 2; i++) begin
         i_vld = 1'b1; {i_res, i_htId} = rand_item();
         nxt();
      end
      i_vld = 1'b0;
      nxt();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_vld !== 1'b0 || o_res !== 64'd0 || o_htId !== 9'd0) begin errors++; $display("FAIL rstmid_out got=%b %h %h exp=0 0 0", o_vld, o_res, o_htId); end
      checks++; if (o_issue_rdy !== 1'b1 || o_idle !== 1'b1) begin errors++; $display("FAIL rstmid_rdy_idle got=%b%b exp=11", o_issue_rdy, o_idle); end
      checks++; if (o_err !== 2'b00 || o_done_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_err_done got=%b/%0d exp=00/0", o_err, o_done_cnt); end
      nxt();
      rst_n = 1'b1;
      got_q.delete();
      nxt();
      issue_n(1);
      it = rand_item();
      i_vld = 1'b1; {i_res, i_htId} = it; i_rdy = 1'b1;
      nxt();
      i_vld = 1'b0;
      wait_got(1, 50, ok);
      nxt();
      checks++; if (!ok || got_q.size() != 1 || got_q[0] !== it) begin errors++; $display("FAIL rstmid_after got=%0d items exp=1 item %h", got_q.size(), it); end
      checks++; if (o_done_cnt !== 32'd1 || o_idle !== 1'b1) begin errors++; $display("FAIL rstmid_done got=%0d idle=%b exp 1 1", o_done_cnt, o_idle); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_stall_fill();
      test_corner_full_push_pop();
      test_overflow();
      test_stream();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
